// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the z8 data-memory port between the load/store unit (r0)
// and the debug/DMA loader (r1), with a bounded burst lock and registered read responses.
module dmem_arbiter #(
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 16,
  parameter int         MAX_BURST = 4,
  parameter logic [1:0] IDLE_OP   = 2'b00,
  parameter logic [1:0] MEM_READ  = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic [1:0]        r0_op,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_ready,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  input  logic [1:0]        r1_op,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_ready,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);

  logic              last_owner;
  logic              lock_q;
  logic [2:0]        burst_cnt;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              r0_vld_p1;
  logic              r1_vld_p1;
  logic [DATA_W-1:0] r0_rdata_p1;
  logic [DATA_W-1:0] r1_rdata_p1;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt >= BURST_MAX) ? BURST_MAX : cnt + 3'd1;
  endfunction

  // lock_q always belongs to last_owner, since every transfer updates both together
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (r0_valid && r1_valid) begin
        if (lock_q && (burst_cnt < BURST_MAX)) begin
          gnt1 = last_owner;
        end else begin
          gnt1 = ~last_owner;
        end
        gnt0 = ~gnt1;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  assign xfer     = gnt0 | gnt1;
  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    mem_op    = IDLE_OP;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_op    = r0_op;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_op    = r1_op;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // p0 -> p1: arbitration state and read-response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner  <= 1'b1;
      burst_cnt   <= 3'd0;
      lock_q      <= 1'b0;
      r0_vld_p1   <= 1'b0;
      r1_vld_p1   <= 1'b0;
      r0_rdata_p1 <= '0;
      r1_rdata_p1 <= '0;
    end else begin
      if (xfer) begin
        last_owner <= gnt1;
        burst_cnt  <= (gnt1 == last_owner) ? sat_inc(burst_cnt) : 3'd1;
        lock_q     <= gnt1 ? r1_lock : r0_lock;
      end else begin
        burst_cnt <= 3'd0;
      end
      r0_vld_p1 <= gnt0 && (r0_op == MEM_READ);
      r1_vld_p1 <= gnt1 && (r1_op == MEM_READ);
      if (gnt0 && (r0_op == MEM_READ)) r0_rdata_p1 <= mem_rdata;
      if (gnt1 && (r1_op == MEM_READ)) r1_rdata_p1 <= mem_rdata;
    end
  end

  // A reset arriving in the response cycle hides the pending rvalid immediately
  assign r0_rvalid = r0_vld_p1 & ~reset;
  assign r1_rvalid = r1_vld_p1 & ~reset;
  assign r0_rdata  = r0_rdata_p1;
  assign r1_rdata  = r1_rdata_p1;

endmodule
